// File: rtl/probe_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : probe_arb_pkg                                                |
// | Description : Shared types for probe_event_arbiter: FSM state enum, the    |
// |               log entry struct and the id width. The log entry struct is   |
// |               sized from the default parameter values held here. Adjust    |
// |               these localparams if the arbiter is built with other         |
// |               NUM_REQ / DATA_W values.                                     |
// |               MAGMA_PROBE_ARB_TIMESTAMP_EN adds a 32-bit ts field.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package probe_arb_pkg;

   localparam int NUM_REQ_DEF = 3;
   localparam int DATA_W_DEF  = 8;
   localparam int CNT_W_DEF   = 8;
   localparam int ID_W        = $clog2(NUM_REQ_DEF);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_e;

   typedef struct packed {
      logic [ID_W-1:0]       id;
      logic [DATA_W_DEF-1:0] data;
`ifdef MAGMA_PROBE_ARB_TIMESTAMP_EN
      logic [31:0]           ts;
`endif
   } log_entry_t;

endpackage
`default_nettype wire

// File: rtl/probe_event_arbiter_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rr_pick                                                      |
// | Description : Combinational round-robin picker. Searches pending_i         |
// |               starting at last_grant_i+1, wrapping modulo N, and reports   |
// |               the first set bit.                                           |
// | Ports       : pending_i      - request vector                              |
// |               last_grant_i   - index granted most recently                 |
// |               grant_valid_o  - some request is pending                     |
// |               grant_idx_o    - index of the winning request                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rr_pick #(
   parameter int N  = 3,
   parameter int IW = 2
) (
   input  logic [N-1:0]  pending_i,
   input  logic [IW-1:0] last_grant_i,
   output logic          grant_valid_o,
   output logic [IW-1:0] grant_idx_o
);

   logic [IW:0]   w_sum;
   logic [IW-1:0] w_sel;

   // Walk from the farthest candidate (last_grant itself) towards the nearest
   // (last_grant+1) so that the nearest pending request is written last and wins.
   always_comb begin
      grant_valid_o = 1'b0;
      grant_idx_o   = '0;
      w_sum         = '0;
      w_sel         = '0;
      for (int k = N; k >= 1; k--) begin
         w_sum = {1'b0, last_grant_i} + (IW+1)'(k);
         if (w_sum >= (IW+1)'(N)) begin
            w_sum = w_sum - (IW+1)'(N);
         end
         w_sel = IW'(w_sum);
         if (pending_i[w_sel]) begin
            grant_valid_o = 1'b1;
            grant_idx_o   = w_sel;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/probe_event_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : probe_event_arbiter                                          |
// | Description : Captures single-cycle probe events into per-source holding   |
// |               slots and serialises them round-robin onto one valid/ready   |
// |               log stream. Sticky per-source overflow flags and a           |
// |               saturating drop counter record events lost to a full slot.   |
// |               Optional macro MAGMA_PROBE_ARB_TIMESTAMP_EN adds a           |
// |               free-running cycle counter, per-slot timestamps and log_ts.  |
// | Ports       : CLK, ASYNCRESETN (async, active low)                         |
// |               arm                  - 1 capture, 0 drain and stop           |
// |               evt_valid / evt_data - per-source event strobe and payload   |
// |               log_valid / log_ready / log_id / log_data - log stream       |
// |               overflow, drop_count - loss reporting (cleared by reset)     |
// |               busy                 - FSM not idle                          |
// |               log_ts               - capture timestamp (macro only)        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module probe_event_arbiter
   import probe_arb_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic                        CLK,
   input  logic                        ASYNCRESETN,
   input  logic                        arm,
   input  logic [NUM_REQ-1:0]          evt_valid,
   input  logic [NUM_REQ*DATA_W-1:0]   evt_data,
   output logic                        log_valid,
   input  logic                        log_ready,
   output logic [$clog2(NUM_REQ)-1:0]  log_id,
   output logic [DATA_W-1:0]           log_data,
   output logic [NUM_REQ-1:0]          overflow,
   output logic [CNT_W-1:0]            drop_count,
   output logic                        busy
`ifdef MAGMA_PROBE_ARB_TIMESTAMP_EN
   ,
   output logic [31:0]                 log_ts
`endif
);

   localparam int               IW      = $clog2(NUM_REQ);
   localparam int               SUM_W   = CNT_W + 5;   // room for up to 16 drops per cycle
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_e             state_q, state_d;
   logic [NUM_REQ-1:0] pend_q, pend_d;
   logic [DATA_W-1:0]  slot_q [NUM_REQ];
   logic [DATA_W-1:0]  slot_d [NUM_REQ];
   logic [IW-1:0]      last_q, last_d;
   logic               vld_q, vld_d;
   log_entry_t         out_q, out_d;
   logic [NUM_REQ-1:0] ovf_q, ovf_d;
   logic [CNT_W-1:0]   drop_q, drop_d;

   logic               capture_en;
   logic               out_free;
   logic               grant_vld;
   logic [IW-1:0]      grant_idx;
   logic [NUM_REQ-1:0] grant_oh;
   logic [4:0]         ndrop;
   logic [SUM_W-1:0]   drop_sum;

`ifdef MAGMA_PROBE_ARB_TIMESTAMP_EN
   logic [31:0] ts_q;
   logic [31:0] slot_ts_q [NUM_REQ];
   logic [31:0] slot_ts_d [NUM_REQ];
`endif

   rr_pick #(
      .N  (NUM_REQ),
      .IW (IW)
   ) u_pick (
      .pending_i     (pend_q),
      .last_grant_i  (last_q),
      .grant_valid_o (grant_vld),
      .grant_idx_o   (grant_idx)
   );

   // FSM state register
   always_ff @(posedge CLK or negedge ASYNCRESETN) begin
      if (!ASYNCRESETN) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state; a returning arm during DRAIN takes priority over finishing
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (arm) state_d = RUN;
         RUN:     if (!arm) state_d = DRAIN;
         DRAIN: begin
            if (arm) begin
               state_d = RUN;
            end else if ((pend_q == '0) && !vld_q) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      busy       = (state_q != IDLE);
      capture_en = (state_q == RUN);
   end

   // Slot capture, arbitration and loss accounting
   always_comb begin
      pend_d   = pend_q;
      slot_d   = slot_q;
      ovf_d    = ovf_q;
      out_d    = out_q;
      vld_d    = vld_q;
      last_d   = last_q;
      ndrop    = '0;
      grant_oh = '0;
`ifdef MAGMA_PROBE_ARB_TIMESTAMP_EN
      slot_ts_d = slot_ts_q;
`endif
      out_free = !vld_q || log_ready;

      for (int i = 0; i < NUM_REQ; i++) begin
         grant_oh[i] = out_free && grant_vld && (grant_idx == IW'(i));
         if (grant_oh[i]) begin
            pend_d[i] = 1'b0;
         end
         // A slot being granted this cycle may refill; otherwise a full slot keeps
         // its oldest payload and the new event is lost.
         if (capture_en && evt_valid[i]) begin
            if (pend_q[i] && !grant_oh[i]) begin
               ovf_d[i] = 1'b1;
               ndrop    = ndrop + 5'd1;
            end else begin
               pend_d[i] = 1'b1;
               slot_d[i] = evt_data[i*DATA_W +: DATA_W];
`ifdef MAGMA_PROBE_ARB_TIMESTAMP_EN
               slot_ts_d[i] = ts_q;
`endif
            end
         end
      end

      if (out_free) begin
         vld_d = grant_vld;
         if (grant_vld) begin
            out_d.id   = grant_idx;
            out_d.data = slot_q[grant_idx];
`ifdef MAGMA_PROBE_ARB_TIMESTAMP_EN
            out_d.ts   = slot_ts_q[grant_idx];
`endif
            last_d     = grant_idx;
         end
      end

      drop_sum = SUM_W'(drop_q) + SUM_W'(ndrop);
      drop_d   = (drop_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : drop_sum[CNT_W-1:0];
   end

   always_ff @(posedge CLK or negedge ASYNCRESETN) begin
      if (!ASYNCRESETN) begin
         pend_q <= '0;
         last_q <= IW'(NUM_REQ - 1);
         vld_q  <= 1'b0;
         out_q  <= '0;
         ovf_q  <= '0;
         drop_q <= '0;
         for (int i = 0; i < NUM_REQ; i++) begin
            slot_q[i] <= '0;
         end
      end else begin
         pend_q <= pend_d;
         last_q <= last_d;
         vld_q  <= vld_d;
         out_q  <= out_d;
         ovf_q  <= ovf_d;
         drop_q <= drop_d;
         slot_q <= slot_d;
      end
   end

`ifdef MAGMA_PROBE_ARB_TIMESTAMP_EN
   always_ff @(posedge CLK or negedge ASYNCRESETN) begin
      if (!ASYNCRESETN) begin
         ts_q <= '0;
         for (int i = 0; i < NUM_REQ; i++) begin
            slot_ts_q[i] <= '0;
         end
      end else begin
         ts_q      <= ts_q + 32'd1;
         slot_ts_q <= slot_ts_d;
      end
   end

   assign log_ts = out_q.ts;
`endif

   assign log_valid  = vld_q;
   assign log_id     = out_q.id;
   assign log_data   = out_q.data;
   assign overflow   = ovf_q;
   assign drop_count = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_probe_event_arbiter.sv
`timescale 1ns/1ps
module tb_probe_event_arbiter;

   localparam int N    = 3;
   localparam int DW   = 8;
   localparam int CW   = 8;
   localparam int CMAX = (1 << CW) - 1;

   logic              CLK = 1'b0;
   logic              ASYNCRESETN = 1'b0;
   logic              arm = 1'b0;
   logic [N-1:0]      evt_valid = '0;
   logic [N*DW-1:0]   evt_data = '0;
   logic              log_ready = 1'b0;
   logic              log_valid;
   logic [1:0]        log_id;
   logic [DW-1:0]     log_data;
   logic [N-1:0]      overflow;
   logic [CW-1:0]     drop_count;
   logic              busy;
`ifdef MAGMA_PROBE_ARB_TIMESTAMP_EN
   logic [31:0]       log_ts;
`endif

   probe_event_arbiter dut (
      .CLK         (CLK),
      .ASYNCRESETN (ASYNCRESETN),
      .arm         (arm),
      .evt_valid   (evt_valid),
      .evt_data    (evt_data),
      .log_valid   (log_valid),
      .log_ready   (log_ready),
      .log_id      (log_id),
      .log_data    (log_data),
      .overflow    (overflow),
      .drop_count  (drop_count),
      .busy        (busy)
`ifdef MAGMA_PROBE_ARB_TIMESTAMP_EN
      ,
      .log_ts      (log_ts)
`endif
   );

   always #5 CLK = ~CLK;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model: 0 = idle, 1 = run, 2 = drain
   int            m_state;
   bit            m_pend [N];
   logic [DW-1:0] m_data [N];
   logic [31:0]   m_sts  [N];
   int            m_last;
   bit            m_valid;
   int            m_id;
   logic [DW-1:0] m_out;
   logic [31:0]   m_out_ts;
   bit            m_ovf [N];
   int            m_drops;
   logic [31:0]   m_ts;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_state = 0; m_last = N - 1; m_valid = 0; m_id = 0; m_out = '0; m_out_ts = '0;
      m_drops = 0; m_ts = '0;
      for (int i = 0; i < N; i++) begin
         m_pend[i] = 0; m_data[i] = '0; m_sts[i] = '0; m_ovf[i] = 0;
      end
   endtask

   // One rising edge of the specified behaviour, using the inputs currently driven
   task automatic model_edge();
      bit            free;
      bit            any;
      int            g;
      int            drops;
      int            nst;
      logic [DW-1:0] gdata;
      logic [31:0]   gts;
      free = !m_valid || (log_ready === 1'b1);
      g = -1;
      if (free) begin
         for (int k = 1; k <= N; k++) begin
            if (g < 0 && m_pend[(m_last + k) % N]) g = (m_last + k) % N;
         end
      end
      any = 0;
      for (int i = 0; i < N; i++) any |= m_pend[i];
      case (m_state)
         0:       nst = arm ? 1 : 0;
         1:       nst = arm ? 1 : 2;
         default: nst = arm ? 1 : ((!any && !m_valid) ? 0 : 2);
      endcase
      gdata = '0; gts = '0;
      if (g >= 0) begin
         gdata = m_data[g]; gts = m_sts[g]; m_pend[g] = 0;
      end
      drops = 0;
      if (m_state == 1) begin
         for (int i = 0; i < N; i++) begin
            if (evt_valid[i]) begin
               if (m_pend[i]) begin
                  m_ovf[i] = 1; drops++;
               end else begin
                  m_pend[i] = 1; m_data[i] = evt_data[i*DW +: DW]; m_sts[i] = m_ts;
               end
            end
         end
      end
      if (free) begin
         m_valid = (g >= 0);
         if (g >= 0) begin
            m_id = g; m_out = gdata; m_out_ts = gts; m_last = g;
         end
      end
      m_drops = (m_drops + drops > CMAX) ? CMAX : m_drops + drops;
      m_state = nst;
      m_ts    = m_ts + 32'd1;
   endtask

   task automatic compare_all();
      logic [N-1:0] ov;
      for (int i = 0; i < N; i++) ov[i] = m_ovf[i];
      chk("log_valid", 64'(log_valid), 64'(m_valid));
      if (m_valid) begin
         chk("log_id", 64'(log_id), 64'(m_id));
         chk("log_data", 64'(log_data), 64'(m_out));
`ifdef MAGMA_PROBE_ARB_TIMESTAMP_EN
         chk("log_ts", 64'(log_ts), 64'(m_out_ts));
`endif
      end
      chk("overflow", 64'(overflow), 64'(ov));
      chk("drop_count", 64'(drop_count), 64'(m_drops));
      chk("busy", 64'(busy), 64'(m_state != 0));
   endtask

   task automatic step();
      model_edge();
      @(posedge CLK);
      #1;
      compare_all();
   endtask

   task automatic do_reset();
      ASYNCRESETN = 1'b0; arm = 1'b0; evt_valid = '0; evt_data = '0; log_ready = 1'b0;
      model_reset();
      @(posedge CLK);
      #1;
      ASYNCRESETN = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset values
      model_reset();
      #12;
      chk("rst_log_valid", 64'(log_valid), 64'd0);
      chk("rst_log_id", 64'(log_id), 64'd0);
      chk("rst_log_data", 64'(log_data), 64'd0);
      chk("rst_overflow", 64'(overflow), 64'd0);
      chk("rst_drop_count", 64'(drop_count), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      @(posedge CLK); #1;
      ASYNCRESETN = 1'b1;

      // Single event
      arm = 1'b1; log_ready = 1'b1;
      step();
      chk("arm_busy", 64'(busy), 64'd1);
      evt_valid = 3'b001; evt_data = {8'h00, 8'h00, 8'hA5};
      step();
      chk("single_not_yet", 64'(log_valid), 64'd0);
      evt_valid = '0;
      step();
      chk("single_valid", 64'(log_valid), 64'd1);
      chk("single_id", 64'(log_id), 64'd0);
      chk("single_data", 64'(log_data), 64'hA5);
      step();
      chk("single_done", 64'(log_valid), 64'd0);

      // Round robin from a fresh last_grant
      do_reset();
      arm = 1'b1; log_ready = 1'b1;
      step();
      evt_valid = 3'b111; evt_data = {8'h30, 8'h20, 8'h10};
      step();
      evt_valid = '0;
      for (int i = 0; i < N; i++) begin
         step();
         chk("rr_id", 64'(log_id), 64'(i));
         chk("rr_data", 64'(log_data), 64'((i + 1) * 16));
      end
      step();
      evt_valid = 3'b111;
      step();
      evt_valid = '0;
      step();
      chk("rr_repeat_id", 64'(log_id), 64'd0);
      step(); step(); step();

      // Backpressure and overflow
      do_reset();
      arm = 1'b1; log_ready = 1'b0;
      step();
      evt_valid = 3'b010; evt_data = {8'h00, 8'h11, 8'h00};
      step();
      evt_valid = '0;
      step();
      evt_valid = 3'b010; evt_data = {8'h00, 8'h22, 8'h00};
      step();
      evt_valid = 3'b010; evt_data = {8'h00, 8'h33, 8'h00};
      step();
      evt_valid = '0;
      step();
      chk("bp_hold_id", 64'(log_id), 64'd1);
      chk("bp_hold_data", 64'(log_data), 64'h11);
      chk("bp_overflow", 64'(overflow), 64'b010);
      chk("bp_drop", 64'(drop_count), 64'd1);
      log_ready = 1'b1;
      step();
      chk("bp_oldest_kept", 64'(log_data), 64'h22);
      step();
      chk("bp_empty", 64'(log_valid), 64'd0);

      // Same-cycle grant and refill
      do_reset();
      arm = 1'b1; log_ready = 1'b1;
      step();
      evt_valid = 3'b001; evt_data = {8'h00, 8'h00, 8'h41};
      step();
      evt_valid = 3'b001; evt_data = {8'h00, 8'h00, 8'h42};
      step();
      chk("refill_first", 64'(log_data), 64'h41);
      chk("refill_nodrop", 64'(drop_count), 64'd0);
      evt_valid = '0;
      step();
      chk("refill_second", 64'(log_data), 64'h42);
      step();

      // Drain
      do_reset();
      arm = 1'b1; log_ready = 1'b0;
      step();
      evt_valid = 3'b111; evt_data = {8'hC3, 8'hC2, 8'hC1};
      step();
      evt_valid = '0; arm = 1'b0;
      step();
      evt_valid = 3'b111;
      step();
      chk("drain_ignore", 64'(drop_count), 64'd0);
      chk("drain_busy", 64'(busy), 64'd1);
      evt_valid = '0; log_ready = 1'b1;
      for (int c = 0; c < 10 && busy; c++) step();
      chk("drain_idle", 64'(busy), 64'd0);

      // Saturating drop counter with multiple drops per cycle
      do_reset();
      arm = 1'b1; log_ready = 1'b0;
      step();
      evt_valid = 3'b111;
      for (int c = 0; c < 100; c++) begin
         evt_data = N*DW'($urandom);
         step();
      end
      evt_valid = '0;
      chk("sat_drop", 64'(drop_count), 64'(CMAX));
      chk("sat_ovf", 64'(overflow), 64'b111);

      // Asynchronous reset mid-stream
      #2;
      ASYNCRESETN = 1'b0;
      #1;
      chk("arst_valid", 64'(log_valid), 64'd0);
      chk("arst_ovf", 64'(overflow), 64'd0);
      chk("arst_drop", 64'(drop_count), 64'd0);
      do_reset();

      // Randomised traffic
      arm = 1'b1;
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 15) == 0) arm = ~arm;
         evt_valid = N'($urandom);
         evt_data  = N*DW'($urandom);
         log_ready = ($urandom_range(0, 3) != 0);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
